reduction_gate_pipe: RTL and testbench

REDUCTION_GATE_PIPE -- requirements
Module: reduction_gate_pipe

---
 rtl/reduction_gate_pipe_pkg.sv | 32 +++
 rtl/reduction_gate_pipe_stage.sv | 39 +++
 rtl/reduction_gate_pipe.sv | 68 ++++++
 tb/tb_reduction_gate_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reduction_gate_pipe_pkg.sv
// gate_pkg: reduction mode encodings and tree-shape helpers shared by the gate pipeline.
package gate_pkg;
    localparam int MODE_AND = 0;
    localparam int MODE_OR  = 1;
    localparam int MODE_XOR = 2;
    // Width of tree level j; level 0 is the raw input vector.
    function automatic int level_width(int n, int j);
        int w;
        w = n;
        for (int i = 0; i < j; i++) w = (w + 3) / 4;
        return w;
    endfunction
    // Bit offset of level j inside a flat bus holding every level back to back.
    function automatic int level_offset(int n, int j);
        int o;
        o = 0;
        for (int i = 0; i < j; i++) o += level_width(n, i);
        return o;
    endfunction
    // Pipeline depth: ceil(log4(n)), never less than one register level.
    function automatic int latency(int n);
        int l;
        int w;
        l = 1;
        w = (n + 3) / 4;
        while (w > 1) begin
            w = (w + 3) / 4;
            l++;
        end
        return l;
    endfunction
endpackage

// File: rtl/reduction_gate_pipe_stage.sv
// reduction_stage: one radix-4 tree level with identity padding and a valid-qualified register.
module reduction_stage
    import gate_pkg::*;
#(
    parameter int Width  = 4,
    parameter int Mode   = MODE_AND,
    parameter bit Invert = 1'b0,
    localparam int Groups = (Width + 3) / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [Width-1:0]  data,
    output logic [Groups-1:0] reduced,
    output logic              valid,
    output logic [Groups-1:0] q
);
    logic [4*Groups-1:0] pad;
    always_comb begin
        pad = {(4*Groups){Mode == MODE_AND}};
        pad[Width-1:0] = data;
    end
    for (genvar g = 0; g < Groups; g++) begin : g_grp
        logic [3:0] s;
        assign s = pad[4*g +: 4];
        assign reduced[g] = Invert ^ (Mode == MODE_AND ? &s : Mode == MODE_OR ? |s : ^s);
    end
    // Data only loads with a live sample so the output keeps the last valid value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (en) begin
            valid <= load;
            if (load) q <= reduced;
        end
    end
endmodule

// File: rtl/reduction_gate_pipe.sv
// reduction_gate_pipe: pipelined radix-4 AND/OR/XOR reduction with input bubbles,
// optional output inversion and a saturating count of true results.
module reduction_gate_pipe
    import gate_pkg::*;
#(
    parameter int                  NrOfInputs   = 7,
    parameter logic [NrOfInputs-1:0] BubblesMask = '0,
    parameter int                  Mode         = MODE_AND,
    parameter bit                  InvertOutput = 1'b0,
    parameter int                  CountWidth   = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEnable,
    input  logic                  ClearCount,
    input  logic                  Valid_in,
    input  logic [NrOfInputs-1:0] Inputs,
    output logic                  Result,
    output logic                  Valid_out,
    output logic [CountWidth-1:0] TrueCount
);
    localparam int L    = latency(NrOfInputs);
    localparam int Tot  = level_offset(NrOfInputs, L + 1);
    localparam int Last = level_offset(NrOfInputs, L) - NrOfInputs;
    if (NrOfInputs < 2 || NrOfInputs > 32) begin : g_bad_n
        $error("NrOfInputs must be 2..32");
    end
    if (Mode != MODE_AND && Mode != MODE_OR && Mode != MODE_XOR) begin : g_bad_mode
        $error("Mode must be 0 (AND), 1 (OR) or 2 (XOR)");
    end
    if (CountWidth < 2 || CountWidth > 32) begin : g_bad_cw
        $error("CountWidth must be 2..32");
    end
    // Every tree level lives back to back in one flat bus; level 0 is the bubbled input.
    logic [Tot-1:0]            bus;
    logic [Tot-NrOfInputs-1:0] rbus;
    logic [L:0]                vbus;
    assign bus[NrOfInputs-1:0] = Inputs ^ BubblesMask;
    assign vbus[0]             = Valid_in;
    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int W = level_width(NrOfInputs, j);
        localparam int O = level_width(NrOfInputs, j + 1);
        reduction_stage #(
            .Width (W),
            .Mode  (Mode),
            .Invert(j == L - 1 ? InvertOutput : 1'b0)
        ) u_stage (
            .clk    (Clock),
            .rst    (Reset),
            .en     (ClockEnable),
            .load   (vbus[j]),
            .data   (bus[level_offset(NrOfInputs, j) +: W]),
            .reduced(rbus[level_offset(NrOfInputs, j + 1) - NrOfInputs +: O]),
            .valid  (vbus[j+1]),
            .q      (bus[level_offset(NrOfInputs, j + 1) +: O])
        );
    end
    assign Result    = bus[Tot-1];
    assign Valid_out = vbus[L];
    // Count on the same edge the true sample lands in the Result register.
    always_ff @(posedge Clock) begin
        if (Reset) TrueCount <= '0;
        else if (ClockEnable)
            TrueCount <= ClearCount ? '0
                       : (vbus[L-1] && rbus[Last] && !(&TrueCount)) ? TrueCount + CountWidth'(1)
                       : TrueCount;
    end
endmodule

// File: tb/tb_reduction_gate_pipe.sv
// tb_reduction_gate_pipe: five configurations driven with shared random stimulus and
// checked each cycle against a queue-based behavioural model.
module tb_reduction_gate_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst = 1'b1, ce = 1'b0, clr = 1'b0, vin = 1'b0;
    logic [31:0] din = '0;
    logic        res [5];
    logic        vo  [5];
    logic [31:0] tc  [5];
    logic [15:0] tc0, tc2;
    logic [3:0]  tc1;
    logic [7:0]  tc3;
    logic [1:0]  tc4;
    assign tc[0] = 32'(tc0);
    assign tc[1] = 32'(tc1);
    assign tc[2] = 32'(tc2);
    assign tc[3] = 32'(tc3);
    assign tc[4] = 32'(tc4);
    reduction_gate_pipe #(.NrOfInputs(7), .BubblesMask(7'h00), .Mode(0), .InvertOutput(1'b0), .CountWidth(16)) d0 (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .ClearCount(clr), .Valid_in(vin),
        .Inputs(din[6:0]), .Result(res[0]), .Valid_out(vo[0]), .TrueCount(tc0));
    reduction_gate_pipe #(.NrOfInputs(7), .BubblesMask(7'h01), .Mode(0), .InvertOutput(1'b0), .CountWidth(4)) d1 (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .ClearCount(clr), .Valid_in(vin),
        .Inputs(din[6:0]), .Result(res[1]), .Valid_out(vo[1]), .TrueCount(tc1));
    reduction_gate_pipe #(.NrOfInputs(32), .BubblesMask(32'h0), .Mode(2), .InvertOutput(1'b1), .CountWidth(16)) d2 (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .ClearCount(clr), .Valid_in(vin),
        .Inputs(din), .Result(res[2]), .Valid_out(vo[2]), .TrueCount(tc2));
    reduction_gate_pipe #(.NrOfInputs(17), .BubblesMask(17'h0A5A5), .Mode(1), .InvertOutput(1'b1), .CountWidth(8)) d3 (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .ClearCount(clr), .Valid_in(vin),
        .Inputs(din[16:0]), .Result(res[3]), .Valid_out(vo[3]), .TrueCount(tc3));
    reduction_gate_pipe #(.NrOfInputs(3), .BubblesMask(3'b010), .Mode(2), .InvertOutput(1'b0), .CountWidth(2)) d4 (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .ClearCount(clr), .Valid_in(vin),
        .Inputs(din[2:0]), .Result(res[4]), .Valid_out(vo[4]), .TrueCount(tc4));

    int          nn [5] = '{7, 7, 32, 17, 3};
    int          md [5] = '{0, 0, 2, 1, 2};
    bit          iv [5] = '{0, 0, 1, 1, 0};
    int          cw [5] = '{16, 4, 16, 8, 2};
    logic [31:0] mk [5] = '{32'h0, 32'h1, 32'h0, 32'h0A5A5, 32'h2};

    int nvec = 0, nfail = 0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit ref_val(int d, logic [31:0] x);
        bit acc;
        x   = x ^ mk[d];
        acc = (md[d] == 0);
        for (int i = 0; i < nn[d]; i++)
            acc = md[d] == 0 ? (acc & x[i]) : md[d] == 1 ? (acc | x[i]) : (acc ^ x[i]);
        return acc ^ iv[d];
    endfunction

    function automatic int lat(int n);
        int l = 1;
        int p = 4;
        while (p < n) begin
            p *= 4;
            l++;
        end
        return l;
    endfunction

    // Model: each accepted sample is due on a known enabled-edge number.
    int     en_cnt = 0;
    bit     ev [5];
    bit     er [5];
    longint ec [5];
    int     qdue [5][$];
    bit     qval [5][$];
    task automatic model_step();
        bit hit, v;
        if (rst) begin
            en_cnt = 0;
            for (int d = 0; d < 5; d++) begin
                ev[d] = 0; er[d] = 0; ec[d] = 0;
                qdue[d].delete(); qval[d].delete();
            end
        end else if (ce) begin
            en_cnt++;
            for (int d = 0; d < 5; d++) begin
                hit = 0; v = 0;
                if (vin) begin
                    qdue[d].push_back(en_cnt + lat(nn[d]) - 1);
                    qval[d].push_back(ref_val(d, din));
                end
                if (qdue[d].size() > 0 && qdue[d][0] == en_cnt) begin
                    hit = 1;
                    v   = qval[d].pop_front();
                    void'(qdue[d].pop_front());
                end
                ev[d] = hit;
                if (hit) er[d] = v;
                if (clr) ec[d] = 0;
                else if (hit && v && ec[d] < (64'd1 << cw[d]) - 1) ec[d]++;
            end
        end
    endtask
    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            chk($sformatf("d%0d valid_out", d), 64'(vo[d]), 64'(ev[d]));
            chk($sformatf("d%0d result", d), 64'(res[d]), 64'(er[d]));
            chk($sformatf("d%0d true_count", d), 64'(tc[d]), 64'(ec[d]));
        end
    end

    task automatic cyc(bit r, bit e, bit c, bit v, logic [31:0] x);
        rst = r; ce = e; clr = c; vin = v; din = x;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pat();
        int k;
        k = $urandom_range(0, 31);
        case ($urandom_range(0, 6))
            0: return $urandom;
            1: return '1;
            2: return ~(32'h1 << k);
            3: return '0;
            4: return 32'h1 << k;
            5: return 32'h0A5A5;
            default: return 32'hFFFF_FFFE;
        endcase
    endfunction

    initial begin
        chk("pin and 7F", 64'(ref_val(0, 32'h7F)), 64'd1);
        chk("pin and 7E", 64'(ref_val(0, 32'h7E)), 64'd0);
        chk("pin bubble 7E", 64'(ref_val(1, 32'h7E)), 64'd1);
        chk("pin bubble 7F", 64'(ref_val(1, 32'h7F)), 64'd0);
        chk("pin xnor 7", 64'(ref_val(2, 32'h7)), 64'd0);
        chk("pin xnor 3", 64'(ref_val(2, 32'h3)), 64'd1);
        chk("pin lat 7", 64'(lat(7)), 64'd2);
        chk("pin lat 32", 64'(lat(32)), 64'd3);
        chk("pin lat 3", 64'(lat(3)), 64'd1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h7F);
        cyc(0, 1, 0, 1, 32'h7E);
        chk("and 7F vo", 64'(vo[0]), 64'd1);
        chk("and 7F res", 64'(res[0]), 64'd1);
        cyc(0, 1, 0, 0, 0);
        chk("and 7E res", 64'(res[0]), 64'd0);
        cyc(0, 1, 0, 1, 32'h7F);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("ce hold vo", 64'(vo[0]), 64'd0);
        chk("ce hold res", 64'(res[0]), 64'd0);
        cyc(0, 1, 0, 0, 0);
        chk("ce release vo", 64'(vo[0]), 64'd1);
        chk("ce release res", 64'(res[0]), 64'd1);
        cyc(0, 1, 0, 1, 32'h7F);
        cyc(0, 1, 0, 1, 32'h7F);
        cyc(1, 0, 0, 0, 0);
        chk("reset vo", 64'(vo[0]), 64'd0);
        chk("reset res", 64'(res[0]), 64'd0);
        chk("reset tc", 64'(tc[0]), 64'd0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (20) cyc(0, 1, 0, 1, 32'h7E);
        repeat (2) cyc(0, 1, 0, 0, 0);
        chk("saturate tc", 64'(tc[1]), 64'd15);
        cyc(0, 1, 0, 1, 32'h7E);
        cyc(0, 1, 1, 0, 0);
        chk("clear wins vo", 64'(vo[1]), 64'd1);
        chk("clear wins tc", 64'(tc[1]), 64'd0);
        repeat (10) cyc(0, 1, 0, 1, pat());
        repeat (4) cyc(0, 1, 0, 0, 0);
        repeat (3000)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
                $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, pat());
        repeat (4) cyc(0, 1, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
